// File: rtl/gnss_corr_pkg.sv
// Shared types and magnitude encodings for the GNSS correlator front end.
// Carrier mixing arithmetic lives in mix_mag so that every user agrees on the encoding.
package gnss_corr_pkg;

    localparam logic [2:0] IF_MAG_LO  = 3'd1;
    localparam logic [2:0] IF_MAG_HI  = 3'd3;
    localparam logic [2:0] CAR_MAG_LO = 3'd1;
    localparam logic [2:0] CAR_MAG_HI = 3'd2;

    typedef struct packed {
        logic       sign;
        logic [2:0] mag;
    } mix_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } sched_state_t;

    // |IF| x |carrier| from the one-bit magnitude codes; the largest product (6) fits in 3 bits.
    function automatic logic [2:0] mix_mag(input logic if_mag, input logic car_mag);
        logic [2:0] ifm;
        logic [2:0] carm;
        ifm  = if_mag  ? IF_MAG_HI  : IF_MAG_LO;
        carm = car_mag ? CAR_MAG_HI : CAR_MAG_LO;
        return ifm * carm;
    endfunction

endpackage

// File: rtl/mixer_channel_scheduler_if.sv
// Sample-in / tagged-result-out bundle between the IF sampler, the NCO bank and the accumulators.
// Handshake: valid-only, no ready. samp_valid offers one sample for exactly one cycle; the
// scheduler either takes it or drops it and raises overrun. out_valid qualifies one result per cycle.
interface mixer_channel_scheduler_if #(
    parameter int NUM_CH = 12
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              samp_valid;
    logic              if_sign;
    logic              if_mag;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] car_sign;
    logic [NUM_CH-1:0] car_mag;

    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic              out_sign;
    logic [2:0]        out_mag;
    logic              frame_done;

    modport master (
        output samp_valid, if_sign, if_mag, ch_enable, car_sign, car_mag,
        input  out_valid, out_ch, out_sign, out_mag, frame_done
    );

    modport slave (
        input  samp_valid, if_sign, if_mag, ch_enable, car_sign, car_mag,
        output out_valid, out_ch, out_sign, out_mag, frame_done
    );

endinterface

// File: rtl/carrier_mixer.sv
// Sign/magnitude product of one IF sample with one carrier sample.
module carrier_mixer
    import gnss_corr_pkg::*;
(
    input  logic if_sign,
    input  logic if_mag,
    input  logic car_sign,
    input  logic car_mag,
    output mix_t mix
);

    assign mix.sign = ~(if_sign ^ car_sign);
    assign mix.mag  = mix_mag(if_mag, car_mag);

endmodule

// File: rtl/next_set_bit.sv
// Combinational priority finder: lowest set bit of mask at or above start, plus a found flag.
module next_set_bit #(
    parameter int W     = 12,
    localparam int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]   mask,
    input  logic [IDX_W:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan downward so the last hit written is the lowest qualifying bit.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mixer_channel_scheduler.sv
// Time-shares one carrier_mixer across NUM_CH channels: each accepted IF sample is swept
// through the enabled channels in ascending order, one result per clock.
module mixer_channel_scheduler
    import gnss_corr_pkg::*;
#(
    parameter int NUM_CH = 12
) (
    input  logic                      clk,
    input  logic                      rstn,
    mixer_channel_scheduler_if.slave  bus,
    input  logic                      overrun_clr,
    output logic                      busy,
    output logic                      overrun,
    output sched_state_t              state_dbg
);

    localparam int CH_W = $clog2(NUM_CH);

    sched_state_t      state, state_nxt;
    logic              snap_if_sign, snap_if_mag;
    logic [NUM_CH-1:0] snap_en, snap_cs, snap_cm;
    logic [CH_W-1:0]   ch_idx;
    logic [CH_W:0]     next_start;
    logic [CH_W-1:0]   first_idx, next_idx;
    logic              first_found, next_found;
    logic              issuing, last_issue, accept, drop;
    mix_t              mix;

    logic              out_valid_q, out_sign_q, frame_done_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [2:0]        out_mag_q;

    // First channel comes straight from the live mask: it is the mask being snapshotted.
    next_set_bit #(.W(NUM_CH)) u_first (
        .mask  (bus.ch_enable),
        .start ('0),
        .idx   (first_idx),
        .found (first_found)
    );

    assign next_start = {1'b0, ch_idx} + (CH_W + 1)'(1);

    next_set_bit #(.W(NUM_CH)) u_next (
        .mask  (snap_en),
        .start (next_start),
        .idx   (next_idx),
        .found (next_found)
    );

    carrier_mixer u_mixer (
        .if_sign  (snap_if_sign),
        .if_mag   (snap_if_mag),
        .car_sign (snap_cs[ch_idx]),
        .car_mag  (snap_cm[ch_idx]),
        .mix      (mix)
    );

    assign issuing    = (state == SCAN);
    assign last_issue = issuing && !next_found;
    assign accept     = bus.samp_valid && (!issuing || last_issue);
    assign drop       = bus.samp_valid && issuing && next_found;

    assign busy      = issuing;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)          state_nxt = first_found ? SCAN : IDLE;
        else if (last_issue) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_if_sign <= 1'b0;
            snap_if_mag  <= 1'b0;
            snap_en      <= '0;
            snap_cs      <= '0;
            snap_cm      <= '0;
            ch_idx       <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sign_q   <= 1'b0;
            out_mag_q    <= '0;
            frame_done_q <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sign_q   <= 1'b0;
            out_mag_q    <= '0;
            frame_done_q <= 1'b0;
            if (issuing) begin
                out_valid_q  <= 1'b1;
                out_ch_q     <= ch_idx;
                out_sign_q   <= mix.sign;
                out_mag_q    <= mix.mag;
                frame_done_q <= !next_found;
            end else if (accept && !first_found) begin
                // Empty frame: completes immediately with no result.
                frame_done_q <= 1'b1;
            end
            if (accept) begin
                snap_if_sign <= bus.if_sign;
                snap_if_mag  <= bus.if_mag;
                snap_en      <= bus.ch_enable;
                snap_cs      <= bus.car_sign;
                snap_cm      <= bus.car_mag;
                ch_idx       <= first_idx;
            end else if (issuing) begin
                ch_idx <= next_idx;
            end
            overrun <= drop | (overrun & ~overrun_clr);
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_sign   = out_sign_q;
    assign bus.out_mag    = out_mag_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_mixer_channel_scheduler.sv
// Directed bench for mixer_channel_scheduler with hand-computed expected results.
module tb_mixer_channel_scheduler;
    import gnss_corr_pkg::*;

    logic         clk;
    logic         rstn;
    logic         overrun_clr;
    logic         busy;
    logic         overrun;
    sched_state_t state_dbg;
    int           total;
    int           bad;

    mixer_channel_scheduler_if #(.NUM_CH(12)) bus ();

    mixer_channel_scheduler #(.NUM_CH(12)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .overrun_clr (overrun_clr),
        .busy        (busy),
        .overrun     (overrun),
        .state_dbg   (state_dbg)
    );

    // {out_valid, out_ch, out_sign, out_mag, frame_done}
    wire [9:0] obs = {bus.out_valid, bus.out_ch, bus.out_sign, bus.out_mag, bus.frame_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_sample(input logic s, input logic m, input logic [11:0] en,
                              input logic [11:0] cs, input logic [11:0] cm);
        bus.if_sign   = s;
        bus.if_mag    = m;
        bus.ch_enable = en;
        bus.car_sign  = cs;
        bus.car_mag   = cm;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        overrun_clr = 1'b0;
        bus.samp_valid = 1'b0;
        set_sample(1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
        repeat (2) @(negedge clk);
        total++;
        if (obs !== 10'd0 || busy !== 1'b0 || overrun !== 1'b0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL reset_state obs=%h busy=%b ovr=%b st=%0d expected obs=000 busy=0 ovr=0 st=0",
                     obs, busy, overrun, state_dbg);
        end
        rstn = 1'b1;
        tick;
        total++;
        if (obs !== 10'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle obs=%h busy=%b expected obs=000 busy=0", obs, busy);
        end
    endtask

    task automatic test_all_channels;
        logic       es;
        logic [2:0] em;
        set_sample(1'b1, 1'b1, 12'hFFF, 12'h0F0, 12'hAAA);
        bus.samp_valid = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL all_accept busy=%b out_valid=%b expected busy=1 out_valid=0", busy, bus.out_valid);
        end
        for (int i = 0; i < 12; i++) begin
            tick;
            es = (i >= 4 && i <= 7);
            em = (i % 2 == 1) ? 3'd6 : 3'd3;
            total++;
            if (obs !== {1'b1, 4'(i), es, em, (i == 11)}) begin
                bad++;
                $display("FAIL all_ch%0d got=%h expected=%h", i, obs, {1'b1, 4'(i), es, em, (i == 11)});
            end
        end
        tick;
        total++;
        if (obs !== 10'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL all_end obs=%h busy=%b expected obs=000 busy=0", obs, busy);
        end
    endtask

    task automatic test_sparse_mask;
        int chs[3] = '{0, 2, 11};
        set_sample(1'b0, 1'b0, 12'h805, 12'hFFF, 12'hFFF);
        bus.samp_valid = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            total++;
            if (obs !== {1'b1, 4'(chs[k]), 1'b0, 3'd2, (k == 2)}) begin
                bad++;
                $display("FAIL sparse_ch%0d got=%h expected=%h", chs[k], obs,
                         {1'b1, 4'(chs[k]), 1'b0, 3'd2, (k == 2)});
            end
        end
        tick;
        total++;
        if (busy !== 1'b0 || obs !== 10'd0) begin
            bad++;
            $display("FAIL sparse_busy_drop busy=%b obs=%h expected busy=0 obs=000", busy, obs);
        end
    endtask

    task automatic test_back_to_back;
        set_sample(1'b1, 1'b0, 12'h003, 12'h003, 12'h000);
        bus.samp_valid = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        tick;
        total++;
        if (obs !== {1'b1, 4'd0, 1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_f1_ch0 got=%h expected=%h", obs, {1'b1, 4'd0, 1'b1, 3'd1, 1'b0});
        end
        // Offer the next sample while ch1 (the last channel) is issuing.
        set_sample(1'b0, 1'b1, 12'h003, 12'h001, 12'h000);
        bus.samp_valid = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        total++;
        if (obs !== {1'b1, 4'd1, 1'b1, 3'd1, 1'b1} || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_f1_ch1 got=%h busy=%b expected=%h busy=1", obs, busy, {1'b1, 4'd1, 1'b1, 3'd1, 1'b1});
        end
        tick;
        total++;
        if (obs !== {1'b1, 4'd0, 1'b0, 3'd3, 1'b0} || overrun !== 1'b0) begin
            bad++;
            $display("FAIL b2b_f2_ch0 got=%h ovr=%b expected=%h ovr=0", obs, overrun, {1'b1, 4'd0, 1'b0, 3'd3, 1'b0});
        end
        tick;
        total++;
        if (obs !== {1'b1, 4'd1, 1'b1, 3'd3, 1'b1}) begin
            bad++;
            $display("FAIL b2b_f2_ch1 got=%h expected=%h", obs, {1'b1, 4'd1, 1'b1, 3'd3, 1'b1});
        end
        tick;
        total++;
        if (obs !== 10'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end obs=%h busy=%b expected obs=000 busy=0", obs, busy);
        end
    endtask

    task automatic test_overrun;
        set_sample(1'b1, 1'b0, 12'h003, 12'h003, 12'h000);
        bus.samp_valid = 1'b1;
        tick;
        // Still high during ch0's issue cycle: this sample must be dropped.
        set_sample(1'b0, 1'b1, 12'h003, 12'h000, 12'h003);
        tick;
        bus.samp_valid = 1'b0;
        total++;
        if (obs !== {1'b1, 4'd0, 1'b1, 3'd1, 1'b0} || overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_ch0 got=%h ovr=%b expected=%h ovr=1", obs, overrun, {1'b1, 4'd0, 1'b1, 3'd1, 1'b0});
        end
        tick;
        total++;
        if (obs !== {1'b1, 4'd1, 1'b1, 3'd1, 1'b1}) begin
            bad++;
            $display("FAIL ovr_ch1 got=%h expected=%h", obs, {1'b1, 4'd1, 1'b1, 3'd1, 1'b1});
        end
        tick;
        total++;
        if (obs !== 10'd0 || busy !== 1'b0 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_no_extra obs=%h busy=%b ovr=%b expected obs=000 busy=0 ovr=1", obs, busy, overrun);
        end
        overrun_clr = 1'b1;
        tick;
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_clear ovr=%b expected=0", overrun);
        end
        set_sample(1'b1, 1'b0, 12'h003, 12'h003, 12'h000);
        bus.samp_valid = 1'b1;
        tick;
        overrun_clr = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_set_wins ovr=%b expected=1", overrun);
        end
        repeat (2) tick;
        overrun_clr = 1'b1;
        tick;
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ovr_final_clear ovr=%b busy=%b expected ovr=0 busy=0", overrun, busy);
        end
    endtask

    task automatic test_snapshot;
        int chs[4] = '{0, 1, 6, 7};
        set_sample(1'b1, 1'b1, 12'h0C3, 12'h000, 12'h000);
        bus.samp_valid = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        set_sample(1'b0, 1'b0, 12'h000, 12'hFFF, 12'hFFF);
        for (int k = 0; k < 4; k++) begin
            tick;
            total++;
            if (obs !== {1'b1, 4'(chs[k]), 1'b0, 3'd3, (k == 3)}) begin
                bad++;
                $display("FAIL snap_ch%0d got=%h expected=%h", chs[k], obs,
                         {1'b1, 4'(chs[k]), 1'b0, 3'd3, (k == 3)});
            end
        end
        tick;
        total++;
        if (obs !== 10'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL snap_end obs=%h busy=%b expected obs=000 busy=0", obs, busy);
        end
    endtask

    task automatic test_zero_mask;
        set_sample(1'b1, 1'b1, 12'h000, 12'hFFF, 12'hFFF);
        bus.samp_valid = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        total++;
        if (obs !== 10'b00000_00001 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_pulse obs=%h busy=%b expected obs=001 busy=0", obs, busy);
        end
        tick;
        total++;
        if (obs !== 10'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_after obs=%h busy=%b expected obs=000 busy=0", obs, busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        set_sample(1'b1, 1'b1, 12'hFFF, 12'h0F0, 12'hAAA);
        bus.samp_valid = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        repeat (3) tick;
        bus.samp_valid = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        repeat (2) tick;
        total++;
        if (obs !== {1'b1, 4'd5, 1'b1, 3'd6, 1'b0} || overrun !== 1'b1) begin
            bad++;
            $display("FAIL mid_ch5 got=%h ovr=%b expected=%h ovr=1", obs, overrun, {1'b1, 4'd5, 1'b1, 3'd6, 1'b0});
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if (obs !== 10'd0 || busy !== 1'b0 || overrun !== 1'b0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL mid_async_reset obs=%h busy=%b ovr=%b st=%0d expected all 0", obs, busy, overrun, state_dbg);
        end
        @(negedge clk);
        rstn = 1'b1;
        set_sample(1'b1, 1'b0, 12'h030, 12'h010, 12'h020);
        bus.samp_valid = 1'b1;
        tick;
        bus.samp_valid = 1'b0;
        tick;
        total++;
        if (obs !== {1'b1, 4'd4, 1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL restart_ch4 got=%h expected=%h", obs, {1'b1, 4'd4, 1'b1, 3'd1, 1'b0});
        end
        tick;
        total++;
        if (obs !== {1'b1, 4'd5, 1'b0, 3'd2, 1'b1}) begin
            bad++;
            $display("FAIL restart_ch5 got=%h expected=%h", obs, {1'b1, 4'd5, 1'b0, 3'd2, 1'b1});
        end
        tick;
        total++;
        if (obs !== 10'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_end obs=%h busy=%b expected obs=000 busy=0", obs, busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_all_channels;
        test_sparse_mask;
        test_back_to_back;
        test_overrun;
        test_snapshot;
        test_zero_mask;
        test_reset_mid_frame;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
